mmio_copy_master: RTL and testbench
===================================

Name: mmio_copy_master

Overview:
- Bus initiator for the peripheral bridge port. It performs word copies from a source address range to a destination address range over the shared Addr/WE/Din/Dout bus, without CPU load/store instructions.
- Typical uses: bulk-load timer PRESET/CTRL registers, or snapshot timer registers into a buffer region.
- The CPU programs it through a start pulse and owns the bus whenever `grant` is low.

Parameters:
- LEN_W, 16, width of the word-count field; maximum transfer is 2^LEN_W-1 words.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous active-low reset; asserting (0) clears all state immediately.
- start, input, 1, single-cycle request; sampled only in IDLE, ignored otherwise.
- src_addr, input, 32, first source byte address.
- dst_addr, input, 32, first destination byte address.
- len, input, LEN_W, number of 32-bit words to copy.
- abort, input, 1, terminates the transfer at the next edge.
- grant, input, 1, bus ownership from the CPU-side arbiter; 0 means stall.
- bus_addr, output, 32, Addr to the bridge.
- bus_we, output, 1, WE to the bridge.
- bus_wdata, output, 32, Din to the bridge.
- bus_rdata, input, 32, Dout from the bridge; combinational, valid in the same cycle as bus_addr.
- busy, output, 1, high in READ and WRITE.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, status: misaligned address; valid while done=1 and held until the next start.
- aborted, output, 1, status: terminated by abort; same validity as err.
- remaining, output, LEN_W, number of words not yet written.

Behaviour:
- Reset values: state=IDLE; bus_addr=0; bus_we=0; bus_wdata=0; busy=0; done=0; err=0; aborted=0; remaining=0; internal read buffer=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1:
  - Latch src, dst and len; clear err and aborted.
  - If src[1:0]!=0 or dst[1:0]!=0: err=1, go to DONE, no bus activity.
  - Else if len==0: go to DONE, no bus activity.
  - Else: remaining=len, go to READ.
- READ:
  - Drives bus_addr=cur_src and bus_we=0.
  - On an edge with grant=1: capture bus_rdata into the buffer, cur_src+=4, go to WRITE.
  - On an edge with grant=0: hold the state.
- WRITE:
  - Drives bus_addr=cur_dst, bus_wdata=buffer, bus_we=grant.
  - On an edge with grant=1: cur_dst+=4, remaining-=1. Go to DONE if remaining was 1, else go to READ.
  - On an edge with grant=0: hold the state with bus_we=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Bus outputs when not owning the bus:
  - When grant=0, or in IDLE/DONE: bus_we=0.
  - bus_addr and bus_wdata hold their last values; the arbiter muxes them out.
- Throughput and latency:
  - 2 granted cycles per word.
  - With grant tied high, done is high in the cycle following edge 2N+1, counting the start-sampling edge as edge 1.
- Address arithmetic: 32-bit wrap-around on increment (0xFFFFFFFC+4 = 0); no error is raised.
- abort=1 in READ or WRITE:
  - Next state is DONE with aborted=1; remaining keeps its current value.
  - A WRITE cycle that is granted in the same cycle as abort still commits, because bus_we is not gated by abort, and remaining decrements.
- abort in IDLE or DONE is ignored.
- start while busy or in DONE is ignored; start and abort together in IDLE: start wins.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values. A write in progress may be cut short; no done pulse is produced.
- Reads have no side effects inside this block. Read-sensitive peripherals are the caller's responsibility.

Test Plan:
- Basic copy, grant=1: bench memory model with words A0..A2 = 0x11, 0x22, 0x33; src=0x0, dst=0x100, len=3.
  - Writes appear at 0x100/0x104/0x108 with data 0x11/0x22/0x33.
  - done is high in the cycle after edge 7; remaining=0; err=0.
- Stalls: same transfer with grant toggling 1,0,0,1,...
  - No bus_we while grant=0.
  - Identical final memory contents.
  - Busy cycle count = 6 + number of stall cycles.
- Boundaries:
  - len=0: done one cycle after start, zero bus writes.
  - src=0x2: err=1, done pulse, zero bus accesses.
  - src=0xFFFFFFFC, len=2: the second read address is 0x0.
- Abort:
  - Abort asserted in the WRITE of word 2 (of 4): that write commits; done with aborted=1, remaining=2; no further accesses.
  - Abort in IDLE: no effect.
- Reset: reset=0 asynchronously during READ of word 1.
  - Outputs go to reset values before the next edge; no done pulse.
  - After release, a fresh start copies correctly.
- Bridge integration: src=0x7f00, dst=0x7f10, len=2, real bridge with timer0 CTRL=0x9, PRESET=100.
  - timer1 CTRL reads back 0x9 and PRESET reads back 100.

Source files
------------

// File: rtl/mmio_copy_master.sv
// Bus initiator that copies a block of 32-bit words from one address range to
// another over the peripheral bridge, one read cycle plus one write cycle per word.
module mmio_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             grant,
    output logic [31:0]      bus_addr,
    output logic             bus_we,
    output logic [31:0]      bus_wdata,
    input  logic [31:0]      bus_rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted,
    output logic [LEN_W-1:0] remaining
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | driving cur_src, capturing bus_rdata on a granted edge
    // WRITE | driving cur_dst with the buffered word, committing on a granted edge
    // DONE  | one-cycle completion pulse, status valid
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        cur_src_q, cur_src_d;
    logic [31:0]        cur_dst_q, cur_dst_d;
    logic [31:0]        rbuf_q, rbuf_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               err_q, err_d;
    logic               aborted_q, aborted_d;
    logic [31:0]        hold_addr_q, hold_addr_d;
    logic [31:0]        hold_wdata_q, hold_wdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            rbuf_q       <= '0;
            remaining_q  <= '0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_src_q    <= cur_src_d;
            cur_dst_q    <= cur_dst_d;
            rbuf_q       <= rbuf_d;
            remaining_q  <= remaining_d;
            err_q        <= err_d;
            aborted_q    <= aborted_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_src_d    = cur_src_q;
        cur_dst_d    = cur_dst_q;
        rbuf_d       = rbuf_q;
        remaining_d  = remaining_q;
        err_d        = err_q;
        aborted_d    = aborted_q;
        bus_addr     = hold_addr_q;
        bus_wdata    = hold_wdata_q;
        bus_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_src_d   = src_addr;
                    cur_dst_d   = dst_addr;
                    remaining_d = len;
                    err_d       = 1'b0;
                    aborted_d   = 1'b0;
                    if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                bus_addr = cur_src_q;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (grant) begin
                    rbuf_d    = bus_rdata;
                    cur_src_d = cur_src_q + 32'd4;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                bus_addr  = cur_dst_q;
                bus_wdata = rbuf_q;
                // abort does not gate the strobe, so a granted write always lands
                bus_we    = grant;
                if (grant) begin
                    cur_dst_d   = cur_dst_q + 32'd4;
                    remaining_d = remaining_q - LEN_W'(1);
                    state_d     = (remaining_q == LEN_W'(1)) ? DONE : READ;
                end
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address/data hold their last driven value while the arbiter has the bus.
        hold_addr_d  = bus_addr;
        hold_wdata_d = bus_wdata;
    end

    assign busy      = (state_q == READ) || (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign aborted   = aborted_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_mmio_copy_master.sv
// Scoreboard bench for mmio_copy_master: a word-level copy model predicts bus
// writes and completion status; a negedge monitor pops and compares them.
module tb_mmio_copy_master;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             grant = 1'b1;
    logic [31:0]      bus_addr;
    logic             bus_we;
    logic [31:0]      bus_wdata;
    logic [31:0]      bus_rdata;
    logic             busy;
    logic             done;
    logic             err;
    logic             aborted;
    logic [LEN_W-1:0] remaining;

    mmio_copy_master #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .abort     (abort),
        .grant     (grant),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .aborted   (aborted),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // 4 KB bus memory, aliased on address bits [11:2]; ref_mem is the model's copy.
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    assign bus_rdata = mem[bus_addr[11:2]];

    always @(posedge clk) begin
        if (reset && bus_we) mem[bus_addr[11:2]] = bus_wdata;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic             err;
        logic             ab;
        logic             rem_chk;
        logic [LEN_W-1:0] rem;
    } done_t;

    wr_t   exp_w[$];
    done_t exp_d[$];

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cyc = 0;
    int stall_cyc = 0;
    int gmode = 0;
    int gphase = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // grant modes: 0 tied high, 1 random, 2 repeating 1,0,0
    initial begin
        forever begin
            @(posedge clk);
            #1;
            gphase++;
            case (gmode)
                0:       grant = 1'b1;
                1:       grant = 1'($urandom_range(0, 1));
                default: grant = (gphase % 3 == 0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (busy) begin
                busy_cyc++;
                if (!grant) stall_cyc++;
            end
            if (bus_we) begin
                chk("we_needs_grant", {31'd0, grant}, 32'd1);
                chk("write_expected", {31'd0, exp_w.size() != 0}, 32'd1);
                if (exp_w.size() != 0) begin
                    wr_t w;
                    w = exp_w.pop_front();
                    chk("write_addr", bus_addr, w.addr);
                    chk("write_data", bus_wdata, w.data);
                end
            end
            if (done) begin
                chk("done_expected", {31'd0, exp_d.size() != 0}, 32'd1);
                if (exp_d.size() != 0) begin
                    done_t e;
                    e = exp_d.pop_front();
                    chk("done_err", {31'd0, err}, {31'd0, e.err});
                    chk("done_aborted", {31'd0, aborted}, {31'd0, e.ab});
                    if (e.rem_chk) chk("done_remaining", 32'(remaining), 32'(e.rem));
                end
            end
        end
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        mem[a[11:2]]     = v;
        ref_mem[a[11:2]] = v;
    endtask

    // Model: sequential word copy; abort_word>0 aborts during the WRITE of that word.
    task automatic xfer(input logic [31:0] s, input logic [31:0] d, input int l,
                        input int gm, input int abort_word, input bit abort_at_start);
        logic        e_err;
        int          n;
        int          edges;
        int          exp_lat;
        logic [31:0] as, ad;
        done_t       dr;
        wr_t         w;
        e_err = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        n = e_err ? 0 : ((abort_word > 0) ? abort_word : l);
        for (int i = 0; i < n; i++) begin
            as = s + 32'(4 * i);
            ad = d + 32'(4 * i);
            ref_mem[ad[11:2]] = ref_mem[as[11:2]];
            w.addr = ad;
            w.data = ref_mem[as[11:2]];
            exp_w.push_back(w);
        end
        dr.err     = e_err;
        dr.ab      = (abort_word > 0);
        dr.rem_chk = !e_err;
        dr.rem     = LEN_W'(l - n);
        exp_d.push_back(dr);

        @(posedge clk);
        #1;
        gmode     = gm;
        busy_cyc  = 0;
        stall_cyc = 0;
        src_addr  = s;
        dst_addr  = d;
        len       = LEN_W'(l);
        start     = 1'b1;
        abort     = abort_at_start;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = LEN_W'($urandom);
        edges = 1;
        if (abort_word > 0) begin
            repeat (2 * abort_word - 1) @(posedge clk);
            #1;
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            edges = 2 * abort_word + 1;
        end
        while (!done && edges < 4000) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (gm == 0) begin
            exp_lat = (e_err || l == 0) ? 1 : ((abort_word > 0) ? 2 * abort_word + 1 : 2 * l + 1);
            chk("done_latency", 32'(edges), 32'(exp_lat));
        end
        if (abort_word == 0) chk("busy_cycles", 32'(busy_cyc), 32'(2 * n + stall_cyc));
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("writes_drained", 32'(exp_w.size()), 32'd0);
        chk("status_drained", 32'(exp_d.size()), 32'd0);
    endtask

    initial begin
        int mism;
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i]     = v;
            ref_mem[i] = v;
        end

        #1;
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_status", {30'd0, err, aborted}, 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic copy with grant tied high
        poke(32'h0, 32'h11);
        poke(32'h4, 32'h22);
        poke(32'h8, 32'h33);
        xfer(32'h0, 32'h100, 3, 0, 0, 1'b0);
        chk("basic_mem0", mem[32'h100 >> 2], 32'h11);
        chk("basic_mem1", mem[32'h104 >> 2], 32'h22);
        chk("basic_mem2", mem[32'h108 >> 2], 32'h33);
        chk("basic_remaining", 32'(remaining), 32'd0);

        // Same copy with stalls
        poke(32'h100, 32'h0);
        poke(32'h104, 32'h0);
        poke(32'h108, 32'h0);
        xfer(32'h0, 32'h100, 3, 2, 0, 1'b0);
        chk("stall_mem0", mem[32'h100 >> 2], 32'h11);
        chk("stall_mem2", mem[32'h108 >> 2], 32'h33);

        // Boundaries
        xfer(32'h40, 32'h140, 0, 0, 0, 1'b0);
        xfer(32'h2, 32'h200, 3, 0, 0, 1'b0);
        chk("err_held", {31'd0, err}, 32'd1);
        xfer(32'h40, 32'h203, 2, 0, 0, 1'b0);
        xfer(32'hFFFF_FFFC, 32'h300, 2, 0, 0, 1'b0);

        // Abort during WRITE of word 2 of 4
        xfer(32'h10, 32'h310, 4, 0, 2, 1'b0);
        chk("abort_remaining_held", 32'(remaining), 32'd2);

        // Abort while idle, then start+abort together
        xfer(32'h20, 32'h320, 2, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);
        chk("idle_abort_done", {31'd0, done}, 32'd0);
        chk("idle_abort_status", {31'd0, aborted}, 32'd0);
        xfer(32'h30, 32'h330, 3, 0, 0, 1'b1);

        // Async reset during READ of word 1
        @(posedge clk);
        #1;
        gmode    = 0;
        src_addr = 32'h0;
        dst_addr = 32'h380;
        len      = LEN_W'(3);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_bus_addr", bus_addr, 32'd0);
        chk("midrst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_remaining", 32'(remaining), 32'd0);
        begin
            int dcnt;
            dcnt = 0;
            repeat (4) begin
                @(posedge clk);
                #1;
                if (done) dcnt++;
            end
            reset = 1'b1;
            repeat (4) begin
                @(posedge clk);
                #1;
                if (done) dcnt++;
            end
            chk("midrst_no_done", 32'(dcnt), 32'd0);
        end
        xfer(32'h0, 32'h380, 3, 1, 0, 1'b0);

        // Peripheral-style block: CTRL/PRESET pair copied to the next timer
        poke(32'h7f00, 32'h9);
        poke(32'h7f04, 32'd100);
        xfer(32'h7f00, 32'h7f10, 2, 0, 0, 1'b0);
        chk("timer1_ctrl", mem[32'h7f10 >> 2 & 32'h3ff], 32'h9);
        chk("timer1_preset", mem[32'h7f14 >> 2 & 32'h3ff], 32'd100);

        // Randomized copies
        for (int t = 0; t < 10; t++) begin
            xfer(32'(4 * $urandom_range(0, 255)), 32'h800 + 32'(4 * $urandom_range(0, 255)),
                 int'($urandom_range(1, 12)), int'($urandom_range(0, 2)), 0, 1'b0);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== ref_mem[i]) mism++;
        end
        chk("final_memory", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
